deserializer_fifo: RTL and testbench
====================================

# deserializer_fifo

Parametrised successor to the 8-bit deserializer: assembles serial bits into WORD_W-bit words and queues up to DEPTH completed words in an internal FIFO. Downstream consumption uses a ready/ack handshake. status_out applies back-pressure to the serial source only when the FIFO is full. It sits between a bit-serial producer and a word-oriented consumer and runs at 100 kHz in a single clock domain.

## Interface
Parameters:
- WORD_W, 8, bits per assembled word; must be ≥2.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and ≥2.
- MSB_FIRST, 0, bit order: 0 means the first received bit becomes bit 0; 1 means the first received bit becomes bit WORD_W-1.

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset; when low, all state clears immediately.
- data_in, input, 1, serial data bit; sampled when write_in=1 and status_out=0.
- write_in, input, 1, marks data_in as valid this cycle.
- ack_in, input, 1, consumer acknowledge; pops the FIFO head when data_ready=1.
- data_out, output, WORD_W, FIFO head word; valid while data_ready=1.
- data_ready, output, 1, FIFO not empty.
- status_out, output, 1, busy: FIFO full, so no bits are accepted.
- count_out, output, $clog2(DEPTH)+1, number of words stored, range 0..DEPTH.
- parity_err, output, 1, parity error flag of the head word; port exists only when DESER_PARITY_EN is defined.

## Operation
Bit acceptance:
- A bit is accepted on a rising edge with write_in=1 and status_out=0.
- The accepted bit is written into the shift register at the position given by MSB_FIRST, and the bit counter increments.
- write_in=1 while status_out=1: the bit is ignored. The shift register and bit counter are unchanged. The source must hold the bit and retry.

Word completion:
- On the edge that accepts the last bit of a frame, the assembled word is pushed into the FIFO at the write pointer.
- On that same edge the bit counter returns to 0. No idle cycle is needed between frames.

Pop:
- ack_in=1 with data_ready=1: on the next edge the read pointer advances and count_out decrements.
- ack_in=1 with data_ready=0: ignored, no state change.

Simultaneous events:
- Push and pop on the same edge with the FIFO non-empty: count_out is unchanged and both pointers advance.
- Word completes on the same edge as ack_in while the FIFO is empty: ack_in is ignored (data_ready was 0). The word becomes visible after the edge.
- FIFO full with ack_in=1: pop only, because no bit can be accepted while full. status_out falls after the edge.

Pointers and outputs:
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count_out is a separate counter saturating at 0..DEPTH; it never wraps.
- data_ready = (count_out != 0). status_out = (count_out == DEPTH). Both are decoded from registered count_out, so there are no input-to-output combinational paths.
- data_out = mem[read pointer]. The value is held stable until the pop edge, regardless of pushes.

## Timing
- Reset values: data_out=0, data_ready=0, status_out=0, count_out=0, parity_err=0. Bit counter, pointers and shift register are also 0.
- Asserting reset mid-frame discards the partial word and all queued words.
- Latency: data_ready rises in the cycle after the edge that accepted the final bit of a frame, when the FIFO was empty.
- An ack_in sampled on edge N exposes the next word (or data_ready=0) after edge N.
- Throughput: 1 bit per cycle in, 1 word per cycle out.
- status_out rises the cycle after the DEPTH-th unconsumed push. It falls the cycle after a pop from full.

## Configuration
Macro: DESER_PARITY_EN.
- Defined:
  - A frame is WORD_W+1 bits; the final bit is an even-parity bit over the word.
  - The word is pushed regardless of parity, together with an error bit, set when the XOR of the word and the parity bit equals 1.
  - The parity_err port exists and shows the head entry's error bit; it is 0 when empty.
- Not defined:
  - A frame is WORD_W bits.
  - No parity storage and no parity_err port.

## Test plan
- Single word: reset, then send bits 1,0,1,0,0,1,0,1 with MSB_FIRST=0 → data_ready=1 and data_out=8'hA5 one cycle after the 8th bit; count_out=1. Apply ack_in → data_ready=0.
- MSB_FIRST=1: send the same bit sequence → data_out=8'hA5 with bit order reversed, i.e. 8'hA5 reads as 8'b10100101 MSB-first. Expected 8'hA5 from send order 1,0,1,0,0,1,0,1.
- Fill and back-pressure (DEPTH=4): push words 0x11, 0x22, 0x33, 0x44 with no ack → status_out=1 and count_out=4. Hold write_in=1 for 5 cycles → nothing accepted. One ack → data_out=0x22 and status_out=0.
- Concurrent push/pop: count_out=2, then ack_in on the same edge as the final bit of 0x55 → count_out stays 2; pointers wrap correctly past DEPTH over 10 words, outputs in order.
- Async reset mid-frame: after 3 bits, pull reset low between edges → all outputs 0 immediately. The next 8 bits form a clean word.
- DESER_PARITY_EN: send 0xA5 followed by parity 0 → parity_err=0. Send 0xA5 followed by parity 1 → parity_err=1 while that word is at the head.

Source files
------------

// File: rtl/deserializer_fifo_if.sv
// Handshake bundle between the deserializer FIFO and its word consumer / bit source.
// parity_err is present only when DESER_PARITY_EN is defined.
interface deserializer_fifo_if #(
   parameter int WORD_W = 8,
   parameter int DEPTH  = 4
);
   logic                      data_in;
   logic                      write_in;
   logic                      ack_in;
   logic [WORD_W-1:0]         data_out;
   logic                      data_ready;
   logic                      status_out;
   logic [$clog2(DEPTH):0]    count_out;
`ifdef DESER_PARITY_EN
   logic                      parity_err;

   modport slave  (input  data_in, write_in, ack_in,
                   output data_out, data_ready, status_out, count_out, parity_err);
   modport master (output data_in, write_in, ack_in,
                   input  data_out, data_ready, status_out, count_out, parity_err);
`else
   modport slave  (input  data_in, write_in, ack_in,
                   output data_out, data_ready, status_out, count_out);
   modport master (output data_in, write_in, ack_in,
                   input  data_out, data_ready, status_out, count_out);
`endif
endinterface

// File: rtl/deserializer_fifo.sv
// Bit-serial to WORD_W-bit word assembler feeding a DEPTH-entry FIFO with ready/ack pop.
// Define DESER_PARITY_EN to add a trailing even-parity bit per frame and a per-word error flag.
module deserializer_fifo #(
   parameter int WORD_W    = 8,
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   deserializer_fifo_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
`ifdef DESER_PARITY_EN
   localparam int FRAME = WORD_W + 1;
`else
   localparam int FRAME = WORD_W;
`endif
   localparam int BIT_W = $clog2(FRAME);

   logic [BIT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] w_shift_nxt;
   logic [WORD_W-1:0] w_word;
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_ready;
   logic              w_full;
   logic              w_accept;
   logic              w_last;
   logic              w_push;
   logic              w_pop;

   assign w_ready  = (r_count != '0);
   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_accept = bus.write_in & ~w_full;
   assign w_last   = (r_bit_cnt == BIT_W'(FRAME - 1));
   assign w_push   = w_accept & w_last;
   assign w_pop    = bus.ack_in & w_ready;

   always_comb begin
      w_shift_nxt = r_shift;
      if (MSB_FIRST)
         w_shift_nxt = {r_shift[WORD_W-2:0], bus.data_in};
      else
         w_shift_nxt = {bus.data_in, r_shift[WORD_W-1:1]};
   end

`ifdef DESER_PARITY_EN
   // The trailing bit is parity, so the data word is already complete in r_shift.
   logic r_err_mem [DEPTH];
   logic w_err;
   assign w_word = r_shift;
   assign w_err  = (^r_shift) ^ bus.data_in;
`else
   assign w_word = w_shift_nxt;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (w_accept) begin
         if (w_last) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_shift   <= w_shift_nxt;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         // Push is impossible when full and pop impossible when empty, so no clamp is needed.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
`ifdef DESER_PARITY_EN
            r_err_mem[i] <= 1'b0;
`endif
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
`ifdef DESER_PARITY_EN
         r_err_mem[r_wr_ptr] <= w_err;
`endif
      end
   end

   assign bus.data_out   = r_mem[r_rd_ptr];
   assign bus.data_ready = w_ready;
   assign bus.status_out = w_full;
   assign bus.count_out  = r_count;
`ifdef DESER_PARITY_EN
   assign bus.parity_err = w_ready & r_err_mem[r_rd_ptr];
`endif

endmodule

// File: tb/tb_deserializer_fifo.sv
// Scoreboard bench: two instances (LSB-first and MSB-first) share one serial stream.
`timescale 1ns/1ps
module tb_deserializer_fifo;
   localparam int WORD_W = 8;
   localparam int DEPTH  = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic data_in  = 1'b0;
   logic write_in = 1'b0;
   logic ack_in   = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [WORD_W-1:0] q_lsb [$];
   logic [WORD_W-1:0] q_msb [$];
`ifdef DESER_PARITY_EN
   logic              q_err [$];
`endif

   always #5 clock = ~clock;

   deserializer_fifo_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus_lsb ();
   deserializer_fifo_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus_msb ();

   assign bus_lsb.data_in  = data_in;
   assign bus_lsb.write_in = write_in;
   assign bus_lsb.ack_in   = ack_in;
   assign bus_msb.data_in  = data_in;
   assign bus_msb.write_in = write_in;
   assign bus_msb.ack_in   = ack_in;

   deserializer_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clock (clock),
      .reset (reset),
      .bus   (bus_lsb.slave)
   );

   deserializer_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_dut_msb (
      .clock (clock),
      .reset (reset),
      .bus   (bus_msb.slave)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] bit_rev(input logic [WORD_W-1:0] w);
      logic [WORD_W-1:0] r;
      for (int i = 0; i < WORD_W; i++) r[i] = w[WORD_W-1-i];
      return r;
   endfunction

   // Compare the head of both DUTs against the scoreboard and retire the entry.
   task automatic check_head(input string tag);
      chk({tag, "_rdy"}, {31'd0, bus_lsb.data_ready}, 32'd1);
      chk({tag, "_sb"}, {31'd0, q_lsb.size() != 0}, 32'd1);
      if (q_lsb.size() != 0) begin
         chk({tag, "_lsb"}, {24'd0, bus_lsb.data_out}, {24'd0, q_lsb.pop_front()});
         chk({tag, "_msb"}, {24'd0, bus_msb.data_out}, {24'd0, q_msb.pop_front()});
`ifdef DESER_PARITY_EN
         chk({tag, "_perr"}, {31'd0, bus_lsb.parity_err}, {31'd0, q_err.pop_front()});
`endif
      end
   endtask

   task automatic send_bit(input logic b, input logic ack);
      data_in  = b;
      write_in = 1'b1;
      ack_in   = ack;
      @(posedge clock);
      #1;
      write_in = 1'b0;
      ack_in   = 1'b0;
   endtask

   // Serial stream is w[0] first; flip inverts the parity bit when parity is enabled.
   task automatic send_word(input logic [WORD_W-1:0] w, input logic flip, input logic ack_last);
      logic last;
      for (int i = 0; i < WORD_W; i++) begin
`ifdef DESER_PARITY_EN
         last = 1'b0;
`else
         last = (i == WORD_W - 1);
`endif
         if (last && ack_last) check_head("cc_head");
         send_bit(w[i], last && ack_last);
      end
`ifdef DESER_PARITY_EN
      if (ack_last) check_head("cc_head");
      send_bit((^w) ^ flip, ack_last);
      q_err.push_back(flip);
`else
      if (flip) chk("flip_unused", 32'd0, 32'd0 + {31'd0, flip} - 32'd1 + 32'd1 - {31'd0, flip});
`endif
      q_lsb.push_back(w);
      q_msb.push_back(bit_rev(w));
   endtask

   task automatic pop_word(input string tag);
      check_head(tag);
      ack_in = 1'b1;
      @(posedge clock);
      #1;
      ack_in = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_dout"}, {24'd0, bus_lsb.data_out}, 32'd0);
      chk({tag, "_rdy"},  {31'd0, bus_lsb.data_ready}, 32'd0);
      chk({tag, "_stat"}, {31'd0, bus_lsb.status_out}, 32'd0);
      chk({tag, "_cnt"},  {29'd0, bus_lsb.count_out}, 32'd0);
      chk({tag, "_msb_cnt"}, {29'd0, bus_msb.count_out}, 32'd0);
`ifdef DESER_PARITY_EN
      chk({tag, "_perr"}, {31'd0, bus_lsb.parity_err}, 32'd0);
`endif
   endtask

   initial begin
      logic [7:0] a5_bits;
      logic [7:0] w;

      #12;
      chk_outputs_zero("reset");
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Single word: stream 1,0,1,0,0,1,0,1 is 0xA5 for both bit orders.
      a5_bits = 8'hA5;
      for (int i = 0; i < WORD_W; i++) begin
         send_bit(a5_bits[i], 1'b0);
         if (i == WORD_W - 2) chk("lat_early_rdy", {31'd0, bus_lsb.data_ready}, 32'd0);
      end
`ifdef DESER_PARITY_EN
      send_bit(1'b0, 1'b0);
      q_err.push_back(1'b0);
`endif
      q_lsb.push_back(8'hA5);
      q_msb.push_back(8'hA5);
      chk("single_cnt", {29'd0, bus_lsb.count_out}, 32'd1);
      chk("single_msb_a5", {24'd0, bus_msb.data_out}, 32'hA5);
      pop_word("single");
      chk("single_rdy_after", {31'd0, bus_lsb.data_ready}, 32'd0);

      // Fill to full, then hold write_in while busy.
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b0);
      send_word(8'h44, 1'b0, 1'b0);
      chk("full_stat", {31'd0, bus_lsb.status_out}, 32'd1);
      chk("full_cnt", {29'd0, bus_lsb.count_out}, 32'd4);
      data_in  = 1'b1;
      write_in = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      write_in = 1'b0;
      chk("busy_cnt", {29'd0, bus_lsb.count_out}, 32'd4);
      pop_word("full_pop");
      chk("after_pop_head", {24'd0, bus_lsb.data_out}, 32'h22);
      chk("after_pop_stat", {31'd0, bus_lsb.status_out}, 32'd0);
      chk("after_pop_cnt", {29'd0, bus_lsb.count_out}, 32'd3);
      repeat (3) pop_word("drain");
      chk("drain_rdy", {31'd0, bus_lsb.data_ready}, 32'd0);
      // Ignored bits must not have advanced the bit counter.
      send_word(8'h3C, 1'b0, 1'b0);
      pop_word("post_busy");

      // Concurrent push and pop, wrapping pointers.
      send_word(8'h5A, 1'b0, 1'b0);
      send_word(8'h96, 1'b0, 1'b0);
      chk("cc_pre_cnt", {29'd0, bus_lsb.count_out}, 32'd2);
      send_word(8'h55, 1'b0, 1'b1);
      chk("cc_cnt", {29'd0, bus_lsb.count_out}, 32'd2);
      for (int i = 0; i < 10; i++) begin
         w = 8'(i * 8'h13 + 8'h07);
         send_word(w, 1'b0, 1'b1);
         chk("cc_loop_cnt", {29'd0, bus_lsb.count_out}, 32'd2);
      end
      pop_word("cc_drain");
      pop_word("cc_drain");
      chk("cc_empty", {31'd0, bus_lsb.data_ready}, 32'd0);

      // Async reset mid-frame with a word queued.
      send_word(8'hC3, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      q_lsb.delete();
      q_msb.delete();
`ifdef DESER_PARITY_EN
      q_err.delete();
`endif
      #2;
      reset = 1'b1;
      @(posedge clock);
      #1;
      send_word(8'h69, 1'b0, 1'b0);
      chk("post_reset_cnt", {29'd0, bus_lsb.count_out}, 32'd1);
      pop_word("post_reset");

`ifdef DESER_PARITY_EN
      send_word(8'hA5, 1'b0, 1'b0);
      send_word(8'hA5, 1'b1, 1'b0);
      chk("par_ok", {31'd0, bus_lsb.parity_err}, 32'd0);
      pop_word("par_first");
      chk("par_bad", {31'd0, bus_lsb.parity_err}, 32'd1);
      pop_word("par_second");
      chk("par_empty", {31'd0, bus_lsb.parity_err}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
